// File: rtl/data_tx_sr.sv
// data_tx_sr: serial frame transmitter.
// Frame = start bit (0), DATA_W data bits LSB first, 16 CRC-16-CCITT bits
// LSB first, end bit (1). One line bit advances per bit_tick strobe.
// Optional: define DATA_TX_ABORT_EN to add the abort input / aborted output.
module data_tx_sr #(
  parameter int          DATA_W   = 64,
  parameter logic [15:0] CRC_POLY = 16'h1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              load,
  input  logic              bit_tick,
`ifdef DATA_TX_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              ready,
  output logic              busy,
  output logic              tx_out,
  output logic              done,
  output logic [15:0]       crc_out
);

  // counter is shared by the data phase (DATA_W bits) and the CRC phase (16 bits)
  localparam int CNT_W = ($clog2(DATA_W) > 4) ? $clog2(DATA_W) : 4;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(15);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [15:0]       crc_q, crc_d;
  logic [15:0]       crc_sr_q, crc_sr_d;
  logic [15:0]       crc_out_q, crc_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              fb;
  logic [15:0]       crc_nxt;

  // next-state / datapath; tx_d is the line value for the *next* state so tx_out stays registered
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    crc_d     = crc_q;
    crc_sr_d  = crc_sr_q;
    crc_out_d = crc_out_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    fb        = crc_q[15] ^ sr_q[0];
    crc_nxt   = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // a bit_tick coinciding with the load is deliberately not consumed
        if (load) begin
          sr_d    = tx_data;
          crc_d   = 16'h0000;
          cnt_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
          tx_d    = sr_q[0];
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          sr_d  = sr_q >> 1;
          crc_d = crc_nxt;
          if (cnt_q == DATA_LAST) begin
            state_d   = S_CRC;
            cnt_d     = '0;
            crc_sr_d  = crc_nxt;
            crc_out_d = crc_nxt;
            tx_d      = crc_nxt[0];
          end else begin
            cnt_d = cnt_q + 1'b1;
            tx_d  = sr_q[1];
          end
        end
      end
      S_CRC: begin
        if (bit_tick) begin
          crc_sr_d = crc_sr_q >> 1;
          if (cnt_q == CRC_LAST) begin
            state_d = S_STOP;
            cnt_d   = '0;
            tx_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            tx_d  = crc_sr_q[1];
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
`ifdef DATA_TX_ABORT_EN
    // abort wins over bit_tick; crc_out keeps whatever it held before this cycle
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      tx_d      = 1'b1;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      crc_out_d = crc_out_q;
    end
`endif
  end

  // state and datapath registers; reset drives the line high immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      crc_q     <= '0;
      crc_sr_q  <= '0;
      crc_out_q <= '0;
      cnt_q     <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      crc_q     <= crc_d;
      crc_sr_q  <= crc_sr_d;
      crc_out_q <= crc_out_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = ~ready;
  assign tx_out  = tx_q;
  assign done    = done_q;
  assign crc_out = crc_out_q;
`ifdef DATA_TX_ABORT_EN
  assign aborted = aborted_q;
`else
  // aborted_q is constant 0 in this build; keep it referenced
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule
